// File: rtl/branch_predict_ctrl_if.sv
// Fetch / resolve / redirect bundle between the front end and the branch
// prediction controller. The master side (fetch + execute) drives requests
// and the slave side (branch_predict_ctrl) returns predictions and updates.
interface branch_predict_ctrl_if #(
    parameter int QDEPTH = 4
) ();
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    // fetch side
    logic             fetch_valid;
    logic [31:0]      fetch_pc;
    logic             btb_hit;
    logic [31:0]      btb_bta;
    logic             fetch_ready;
    logic             pred_taken;
    logic [31:0]      next_pc;

    // resolve side
    logic             resolve_valid;
    logic             resolve_is_br;
    logic             resolve_taken;
    logic [31:0]      resolve_target;

    // redirect / BTB install / status
    logic             flush;
    logic [31:0]      redirect_pc;
    logic             btb_wr_en;
    logic [7:0]       btb_wr_pc;
    logic [31:0]      btb_wr_bta;
    logic [CNT_W-1:0] q_count;
    logic             err_underflow;

    modport master (
        output fetch_valid, fetch_pc, btb_hit, btb_bta,
        output resolve_valid, resolve_is_br, resolve_taken, resolve_target,
        input  fetch_ready, pred_taken, next_pc,
        input  flush, redirect_pc, btb_wr_en, btb_wr_pc, btb_wr_bta,
        input  q_count, err_underflow
    );

    modport slave (
        input  fetch_valid, fetch_pc, btb_hit, btb_bta,
        input  resolve_valid, resolve_is_br, resolve_taken, resolve_target,
        output fetch_ready, pred_taken, next_pc,
        output flush, redirect_pc, btb_wr_en, btb_wr_pc, btb_wr_bta,
        output q_count, err_underflow
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Branch prediction controller: 2-bit saturating-counter PHT indexed by the
// fetch PC, an in-flight queue of predictions retired in order by execute,
// mispredict detection with a one-cycle registered flush/redirect, and a
// registered BTB install request for taken branches the BTB got wrong.
module branch_predict_ctrl #(
    parameter int QDEPTH   = 4,
    parameter int PHT_BITS = 4
) (
    input logic                  clk_i,
    input logic                  reset_i,
    branch_predict_ctrl_if.slave bus
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH) + 1;
    localparam int PHT_N = 1 << PHT_BITS;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(QDEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [1:0]       CTR_INIT  = 2'b01;

    // Saturating 2-bit counter step: up on taken, down on not-taken.
    function automatic logic [1:0] sat_step(input logic [1:0] cur, input logic up);
        logic [1:0] nxt;
        if (up) begin
            nxt = (cur == 2'b11) ? 2'b11 : cur + 2'b01;
        end else begin
            nxt = (cur == 2'b00) ? 2'b00 : cur - 2'b01;
        end
        return nxt;
    endfunction

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [31:0]      qpc_q   [QDEPTH];
    logic             qhit_q  [QDEPTH];
    logic             qpred_q [QDEPTH];
    logic [31:0]      qbta_q  [QDEPTH];
    logic [1:0]       pht_q   [PHT_N];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             flush_q;
    logic [31:0]      redirect_pc_q;
    logic             btb_wr_en_q;
    logic [7:0]       btb_wr_pc_q;
    logic [31:0]      btb_wr_bta_q;
    logic             err_underflow_q;

    // ---------------------------------------------------------------
    // Combinational next-state
    // ---------------------------------------------------------------
    logic               fetch_ready_d;
    logic [PHT_BITS-1:0] fetch_idx_d;
    logic               pred_taken_d;
    logic [31:0]        next_pc_d;
    logic               push_d;
    logic               pop_d;
    logic               underflow_d;
    logic [31:0]        e_pc_d;
    logic               e_hit_d;
    logic               e_pred_d;
    logic [31:0]        e_bta_d;
    logic               mispredict_d;
    logic [31:0]        redirect_pc_d;
    logic               btb_install_d;
    logic               pht_upd_d;
    logic [PHT_BITS-1:0] upd_idx_d;
    logic [1:0]         pht_new_d;
    logic [CNT_W-1:0]   count_d;

    // Fetch-side prediction: reads the PHT before any same-cycle update lands.
    always_comb begin
        fetch_ready_d = (count_q != CNT_FULL) && !flush_q;
        fetch_idx_d   = bus.fetch_pc[PHT_BITS+1:2];
        pred_taken_d  = bus.fetch_valid && bus.btb_hit && pht_q[fetch_idx_d][1];
        if (pred_taken_d) begin
            next_pc_d = bus.btb_bta;
        end else begin
            next_pc_d = bus.fetch_pc + 32'd4;
        end
        push_d = bus.fetch_valid && fetch_ready_d;
    end

    // Resolve-side evaluation of the head entry: mispredict, redirect, BTB install.
    always_comb begin
        pop_d       = bus.resolve_valid && (count_q != CNT_ZERO);
        underflow_d = bus.resolve_valid && (count_q == CNT_ZERO);
        e_pc_d      = qpc_q[head_q];
        e_hit_d     = qhit_q[head_q];
        e_pred_d    = qpred_q[head_q];
        e_bta_d     = qbta_q[head_q];

        mispredict_d = 1'b0;
        if (pop_d) begin
            if (bus.resolve_is_br) begin
                mispredict_d = (bus.resolve_taken != e_pred_d) ||
                               (bus.resolve_taken && e_pred_d &&
                                (bus.resolve_target != e_bta_d));
            end else begin
                mispredict_d = e_pred_d;
            end
        end else begin
            mispredict_d = 1'b0;
        end

        if (bus.resolve_is_br && bus.resolve_taken) begin
            redirect_pc_d = bus.resolve_target;
        end else begin
            redirect_pc_d = e_pc_d + 32'd4;
        end

        btb_install_d = pop_d && bus.resolve_is_br && bus.resolve_taken &&
                        (!e_hit_d || (bus.resolve_target != e_bta_d));

        pht_upd_d = pop_d && bus.resolve_is_br;
        upd_idx_d = e_pc_d[PHT_BITS+1:2];
        pht_new_d = sat_step(pht_q[upd_idx_d], bus.resolve_taken);
    end

    // Occupancy after this cycle's accepted push and pop.
    always_comb begin
        case ({push_d, pop_d})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // ---------------------------------------------------------------
    // Sequential state
    // ---------------------------------------------------------------

    // Queue storage, pointers, PHT and the registered redirect/install outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q          <= PTR_ZERO;
            tail_q          <= PTR_ZERO;
            count_q         <= CNT_ZERO;
            flush_q         <= 1'b0;
            redirect_pc_q   <= 32'd0;
            btb_wr_en_q     <= 1'b0;
            btb_wr_pc_q     <= 8'd0;
            btb_wr_bta_q    <= 32'd0;
            err_underflow_q <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                qpc_q[i]   <= 32'd0;
                qhit_q[i]  <= 1'b0;
                qpred_q[i] <= 1'b0;
                qbta_q[i]  <= 32'd0;
            end
            for (int j = 0; j < PHT_N; j++) begin
                pht_q[j] <= CTR_INIT;
            end
        end else begin
            err_underflow_q <= err_underflow_q | underflow_d;

            // mispredict redirect is a one-cycle pulse; the PC is held otherwise
            flush_q <= mispredict_d;
            if (mispredict_d) begin
                redirect_pc_q <= redirect_pc_d;
            end else begin
                redirect_pc_q <= redirect_pc_q;
            end

            btb_wr_en_q <= btb_install_d;
            if (btb_install_d) begin
                btb_wr_pc_q  <= e_pc_d[7:0];
                btb_wr_bta_q <= bus.resolve_target;
            end else begin
                btb_wr_pc_q  <= btb_wr_pc_q;
                btb_wr_bta_q <= btb_wr_bta_q;
            end

            if (pht_upd_d) begin
                pht_q[upd_idx_d] <= pht_new_d;
            end

            // a mispredict kills everything younger, including this cycle's push
            if (mispredict_d) begin
                head_q  <= PTR_ZERO;
                tail_q  <= PTR_ZERO;
                count_q <= CNT_ZERO;
            end else begin
                if (push_d) begin
                    qpc_q[tail_q]   <= bus.fetch_pc;
                    qhit_q[tail_q]  <= bus.btb_hit;
                    qpred_q[tail_q] <= pred_taken_d;
                    qbta_q[tail_q]  <= bus.btb_bta;
                    tail_q          <= tail_q + PTR_ONE;
                end
                if (pop_d) begin
                    head_q <= head_q + PTR_ONE;
                end
                count_q <= count_d;
            end
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.fetch_ready   = fetch_ready_d;
    assign bus.pred_taken    = pred_taken_d;
    assign bus.next_pc       = next_pc_d;
    assign bus.flush         = flush_q;
    assign bus.redirect_pc   = redirect_pc_q;
    assign bus.btb_wr_en     = btb_wr_en_q;
    assign bus.btb_wr_pc     = btb_wr_pc_q;
    assign bus.btb_wr_bta    = btb_wr_bta_q;
    assign bus.q_count       = count_q;
    assign bus.err_underflow = err_underflow_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed testbench for branch_predict_ctrl (QDEPTH=4, PHT_BITS=4).
// Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
module tb_branch_predict_ctrl;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    branch_predict_ctrl_if #(.QDEPTH(4)) bif ();

    branch_predict_ctrl #(.QDEPTH(4), .PHT_BITS(4)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.fetch_valid    = 1'b0;
        bif.fetch_pc       = 32'd0;
        bif.btb_hit        = 1'b0;
        bif.btb_bta        = 32'd0;
        bif.resolve_valid  = 1'b0;
        bif.resolve_is_br  = 1'b0;
        bif.resolve_taken  = 1'b0;
        bif.resolve_target = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // one fetch cycle that is accepted at the next edge
    task automatic push_one(input logic [31:0] pc, input logic hit, input logic [31:0] bta);
        bif.fetch_valid = 1'b1;
        bif.fetch_pc    = pc;
        bif.btb_hit     = hit;
        bif.btb_bta     = bta;
        tick();
        bif.fetch_valid = 1'b0;
    endtask

    task automatic resolve_one(input logic is_br, input logic taken, input logic [31:0] tgt);
        bif.resolve_valid  = 1'b1;
        bif.resolve_is_br  = is_br;
        bif.resolve_taken  = taken;
        bif.resolve_target = tgt;
        tick();
        bif.resolve_valid  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (bif.q_count !== 3'd0) begin tests_failed++; $display("FAIL reset_qcount got %0d want 0", bif.q_count); end
        tests_run++; if (bif.flush !== 1'b0) begin tests_failed++; $display("FAIL reset_flush got %b want 0", bif.flush); end
        tests_run++; if (bif.redirect_pc !== 32'd0) begin tests_failed++; $display("FAIL reset_redirect got %h want 0", bif.redirect_pc); end
        tests_run++; if ({bif.btb_wr_en, bif.btb_wr_pc, bif.btb_wr_bta} !== 41'd0) begin tests_failed++; $display("FAIL reset_btbwr got %b/%h/%h want 0/0/0", bif.btb_wr_en, bif.btb_wr_pc, bif.btb_wr_bta); end
        tests_run++; if (bif.err_underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", bif.err_underflow); end
        tests_run++; if (bif.fetch_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", bif.fetch_ready); end
    endtask

    task automatic test_predict_basic();
        do_reset();
        bif.fetch_valid = 1'b1; bif.fetch_pc = 32'h100; bif.btb_hit = 1'b1; bif.btb_bta = 32'h200;
        #1;
        tests_run++; if (bif.pred_taken !== 1'b0) begin tests_failed++; $display("FAIL first_pred got %b want 0", bif.pred_taken); end
        tests_run++; if (bif.next_pc !== 32'h104) begin tests_failed++; $display("FAIL first_nextpc got %h want 104", bif.next_pc); end
        tick();
        bif.fetch_valid = 1'b0;
        tests_run++; if (bif.q_count !== 3'd1) begin tests_failed++; $display("FAIL first_push_qcount got %0d want 1", bif.q_count); end
        resolve_one(1'b1, 1'b1, 32'h200);
        tests_run++; if (bif.flush !== 1'b1) begin tests_failed++; $display("FAIL mis_flush got %b want 1", bif.flush); end
        tests_run++; if (bif.redirect_pc !== 32'h200) begin tests_failed++; $display("FAIL mis_redirect got %h want 200", bif.redirect_pc); end
        tests_run++; if (bif.q_count !== 3'd0) begin tests_failed++; $display("FAIL mis_qcount got %0d want 0", bif.q_count); end
        tests_run++; if (bif.btb_wr_en !== 1'b0) begin tests_failed++; $display("FAIL mis_no_install got %b want 0", bif.btb_wr_en); end
        tests_run++; if (bif.fetch_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_ready got %b want 0", bif.fetch_ready); end
        // fetch during flush must be ignored
        push_one(32'h100, 1'b1, 32'h200);
        tests_run++; if (bif.q_count !== 3'd0) begin tests_failed++; $display("FAIL flush_ignores_fetch got %0d want 0", bif.q_count); end
        tests_run++; if (bif.flush !== 1'b0) begin tests_failed++; $display("FAIL flush_one_cycle got %b want 0", bif.flush); end
        bif.fetch_valid = 1'b1; bif.fetch_pc = 32'h100; bif.btb_hit = 1'b1; bif.btb_bta = 32'h200;
        #1;
        tests_run++; if (bif.pred_taken !== 1'b1) begin tests_failed++; $display("FAIL refetch_pred got %b want 1", bif.pred_taken); end
        tests_run++; if (bif.next_pc !== 32'h200) begin tests_failed++; $display("FAIL refetch_nextpc got %h want 200", bif.next_pc); end
        bif.fetch_pc = 32'hFFFF_FFFC; bif.btb_hit = 1'b0;
        #1;
        tests_run++; if (bif.next_pc !== 32'h0) begin tests_failed++; $display("FAIL nextpc_wrap got %h want 0", bif.next_pc); end
        bif.fetch_valid = 1'b0;
        #1;
    endtask

    task automatic test_btb_install();
        do_reset();
        bif.fetch_valid = 1'b1; bif.fetch_pc = 32'h40; bif.btb_hit = 1'b0; bif.btb_bta = 32'h0;
        #1;
        tests_run++; if (bif.next_pc !== 32'h44) begin tests_failed++; $display("FAIL miss_nextpc got %h want 44", bif.next_pc); end
        tick();
        bif.fetch_valid = 1'b0;
        resolve_one(1'b1, 1'b1, 32'h80);
        tests_run++; if (bif.btb_wr_en !== 1'b1) begin tests_failed++; $display("FAIL install_en got %b want 1", bif.btb_wr_en); end
        tests_run++; if (bif.btb_wr_pc !== 8'h40) begin tests_failed++; $display("FAIL install_pc got %h want 40", bif.btb_wr_pc); end
        tests_run++; if (bif.btb_wr_bta !== 32'h80) begin tests_failed++; $display("FAIL install_bta got %h want 80", bif.btb_wr_bta); end
        tests_run++; if ({bif.flush, bif.redirect_pc} !== {1'b1, 32'h80}) begin tests_failed++; $display("FAIL install_redirect got %b/%h want 1/80", bif.flush, bif.redirect_pc); end
        tick();
        tests_run++; if ({bif.btb_wr_en, bif.flush} !== 2'b00) begin tests_failed++; $display("FAIL install_pulse got %b%b want 00", bif.btb_wr_en, bif.flush); end
    endtask

    task automatic test_full_and_wrap();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_one(32'h10 + 32'(4 * i), 1'b0, 32'h0);
        end
        bif.fetch_valid = 1'b1; bif.fetch_pc = 32'h20; bif.btb_hit = 1'b0;
        #1;
        tests_run++; if (bif.q_count !== 3'd4) begin tests_failed++; $display("FAIL full_qcount got %0d want 4", bif.q_count); end
        tests_run++; if (bif.fetch_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready got %b want 0", bif.fetch_ready); end
        // correct pop at full: push is rejected, the slot frees only afterwards
        resolve_one(1'b0, 1'b0, 32'h0);
        bif.fetch_valid = 1'b0;
        tests_run++; if (bif.q_count !== 3'd3) begin tests_failed++; $display("FAIL full_pop_qcount got %0d want 3", bif.q_count); end
        tests_run++; if ({bif.fetch_ready, bif.flush} !== 2'b10) begin tests_failed++; $display("FAIL full_pop_ready got %b%b want 10", bif.fetch_ready, bif.flush); end
        // tail wraps to slot 0
        push_one(32'h24, 1'b0, 32'h0);
        tests_run++; if (bif.q_count !== 3'd4) begin tests_failed++; $display("FAIL wrap_qcount got %0d want 4", bif.q_count); end
        for (int k = 0; k < 3; k++) begin
            resolve_one(1'b0, 1'b0, 32'h0);
        end
        tests_run++; if ({bif.q_count, bif.flush} !== {3'd1, 1'b0}) begin tests_failed++; $display("FAIL wrap_drain got %0d/%b want 1/0", bif.q_count, bif.flush); end
        resolve_one(1'b1, 1'b1, 32'h300);
        tests_run++; if (bif.btb_wr_pc !== 8'h24) begin tests_failed++; $display("FAIL wrap_entry_pc got %h want 24", bif.btb_wr_pc); end
        tests_run++; if ({bif.flush, bif.redirect_pc} !== {1'b1, 32'h300}) begin tests_failed++; $display("FAIL wrap_redirect got %b/%h want 1/300", bif.flush, bif.redirect_pc); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_one(32'h40, 1'b0, 32'h0);
        bif.fetch_valid = 1'b1; bif.fetch_pc = 32'h44; bif.btb_hit = 1'b0;
        resolve_one(1'b0, 1'b0, 32'h0);
        bif.fetch_valid = 1'b0;
        tests_run++; if ({bif.q_count, bif.flush} !== {3'd1, 1'b0}) begin tests_failed++; $display("FAIL b2b_qcount got %0d/%b want 1/0", bif.q_count, bif.flush); end
        resolve_one(1'b1, 1'b1, 32'h90);
        tests_run++; if (bif.btb_wr_pc !== 8'h44) begin tests_failed++; $display("FAIL b2b_order got %h want 44", bif.btb_wr_pc); end
        tick();
    endtask

    task automatic test_same_cycle();
        do_reset();
        push_one(32'h104, 1'b1, 32'h400);
        // mispredicting pop of idx 1 while fetching idx 1: prediction uses 01
        bif.fetch_valid = 1'b1; bif.fetch_pc = 32'h104; bif.btb_hit = 1'b1; bif.btb_bta = 32'h400;
        bif.resolve_valid = 1'b1; bif.resolve_is_br = 1'b1; bif.resolve_taken = 1'b1; bif.resolve_target = 32'h400;
        #1;
        tests_run++; if (bif.pred_taken !== 1'b0) begin tests_failed++; $display("FAIL same_cycle_pred got %b want 0", bif.pred_taken); end
        tick();
        bif.fetch_valid = 1'b0; bif.resolve_valid = 1'b0;
        tests_run++; if ({bif.flush, bif.q_count} !== {1'b1, 3'd0}) begin tests_failed++; $display("FAIL wrongpath_push got %b/%0d want 1/0", bif.flush, bif.q_count); end
        tick();
        bif.fetch_valid = 1'b1;
        #1;
        tests_run++; if (bif.pred_taken !== 1'b1) begin tests_failed++; $display("FAIL post_update_pred got %b want 1", bif.pred_taken); end
        bif.fetch_valid = 1'b0;
        #1;
    endtask

    task automatic test_saturate();
        do_reset();
        for (int r = 0; r < 5; r++) begin
            push_one(32'h104, 1'b1, 32'h400);
            resolve_one(1'b1, 1'b1, 32'h400);
            tick();
        end
        bif.fetch_valid = 1'b1; bif.fetch_pc = 32'h104; bif.btb_hit = 1'b1; bif.btb_bta = 32'h400;
        #1;
        tests_run++; if (bif.pred_taken !== 1'b1) begin tests_failed++; $display("FAIL sat_taken_pred got %b want 1", bif.pred_taken); end
        bif.fetch_valid = 1'b0;
        push_one(32'h104, 1'b1, 32'h400);
        resolve_one(1'b1, 1'b0, 32'h0);
        tests_run++; if ({bif.flush, bif.redirect_pc} !== {1'b1, 32'h108}) begin tests_failed++; $display("FAIL nt_redirect got %b/%h want 1/108", bif.flush, bif.redirect_pc); end
        tick();
        push_one(32'h104, 1'b1, 32'h400);
        resolve_one(1'b1, 1'b0, 32'h0);
        tests_run++; if (bif.flush !== 1'b1) begin tests_failed++; $display("FAIL nt2_flush got %b want 1", bif.flush); end
        tick();
        bif.fetch_valid = 1'b1; bif.fetch_pc = 32'h104; bif.btb_hit = 1'b1; bif.btb_bta = 32'h400;
        #1;
        tests_run++; if ({bif.pred_taken, bif.next_pc} !== {1'b0, 32'h108}) begin tests_failed++; $display("FAIL sat_nt_pred got %b/%h want 0/108", bif.pred_taken, bif.next_pc); end
        bif.fetch_valid = 1'b0;
        #1;
    endtask

    task automatic test_underflow();
        do_reset();
        resolve_one(1'b1, 1'b1, 32'h500);
        tests_run++; if (bif.err_underflow !== 1'b1) begin tests_failed++; $display("FAIL underflow_err got %b want 1", bif.err_underflow); end
        tests_run++; if ({bif.q_count, bif.flush, bif.btb_wr_en} !== {3'd0, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL underflow_state got %0d/%b/%b want 0/0/0", bif.q_count, bif.flush, bif.btb_wr_en); end
        tick();
        tests_run++; if (bif.err_underflow !== 1'b1) begin tests_failed++; $display("FAIL underflow_sticky got %b want 1", bif.err_underflow); end
        do_reset();
        tests_run++; if (bif.err_underflow !== 1'b0) begin tests_failed++; $display("FAIL underflow_clear got %b want 0", bif.err_underflow); end
    endtask

    task automatic test_reset_priority();
        do_reset();
        push_one(32'h40, 1'b0, 32'h0);
        bif.resolve_valid = 1'b1; bif.resolve_is_br = 1'b1; bif.resolve_taken = 1'b1; bif.resolve_target = 32'h80;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bif.resolve_valid = 1'b0;
        tests_run++; if ({bif.flush, bif.btb_wr_en, bif.q_count} !== {1'b0, 1'b0, 3'd0}) begin tests_failed++; $display("FAIL reset_priority got %b/%b/%0d want 0/0/0", bif.flush, bif.btb_wr_en, bif.q_count); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        idle_inputs();
        test_reset();
        test_predict_basic();
        test_btb_install();
        test_full_and_wrap();
        test_back_to_back();
        test_same_cycle();
        test_saturate();
        test_underflow();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
